// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared states, sizes and row-to-bit mapping for the truth-table sweeper
package tt_sweep_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} tt_state_e;
    localparam int TT_ROWS = 8;
    localparam int TT_IN_W = 3;
    function automatic logic [TT_IN_W-1:0] tt_bit(input logic [TT_IN_W-1:0] row);
        return TT_IN_W'(TT_ROWS - 1) - row;
    endfunction
endpackage

// File: rtl/settle_timer.sv
// settle_timer: loadable down-counter that pulses expire once per SETTLE_CYCLES+1 enabled cycles
module settle_timer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);
    localparam int W = SETTLE_CYCLES > 0 ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [W-1:0] RELOAD = W'(SETTLE_CYCLES);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        expire = en && cnt_q == '0;
        cnt_d  = (load || expire) ? RELOAD : en ? cnt_q - W'(1) : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: drives all 8 input rows of a 3-input circuit, samples it and scores against a truth table
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [7:0]         expected,
    input  logic               dut_out,
    output logic [TT_IN_W-1:0] dut_in,
    output logic               busy,
    output logic               done,
    output logic [7:0]         captured,
    output logic [7:0]         mismatch,
    output logic               pass
);
    tt_state_e state_q, state_d;
    logic [TT_IN_W-1:0] row_q, row_d;
    logic [7:0] exp_q, exp_d, cap_q, cap_d, mis_q, mis_d;
    logic pass_q, pass_d, go, run_en, expire;
    assign go     = state_q == IDLE && start && !abort;
    assign run_en = state_q == RUN && !abort;
    settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (go),
        .en     (run_en),
        .expire (expire)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            exp_q   <= '0;
            cap_q   <= '0;
            mis_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            exp_q   <= exp_d;
            cap_q   <= cap_d;
            mis_q   <= mis_d;
            pass_q  <= pass_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = RUN;
            RUN:     if (abort) state_d = IDLE;
                     else if (expire && row_q == TT_IN_W'(TT_ROWS - 1)) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        exp_d = go ? expected : exp_q;
        cap_d = go ? '0 : cap_q;
        mis_d = go ? '0 : mis_q;
        if (expire) begin
            cap_d[tt_bit(row_q)] = dut_out;
            mis_d[tt_bit(row_q)] = dut_out ^ exp_q[tt_bit(row_q)];
        end
        pass_d = (state_q == RUN && state_d == DONE) ? mis_d == '0 : go ? 1'b0 : pass_q;
        // row doubles as the driven input, so it parks at 0 whenever the sweep is not running
        row_d  = (state_q == RUN && state_d == RUN) ? row_q + TT_IN_W'(expire) : '0;
    end
    always_comb begin
        busy     = state_q == RUN;
        done     = state_q == DONE;
        dut_in   = row_q;
        captured = cap_q;
        mismatch = mis_q;
        pass     = pass_q;
    end
endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb_tt_sweep_ctrl: table-driven and directed checks of tt_sweep_ctrl at SETTLE_CYCLES 4 and 0
module tb_tt_sweep_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, abort = 1'b0, dut_out;
    logic [7:0] expected = 8'h00;
    logic [2:0] dut_in;
    logic       busy, done, pass;
    logic [7:0] captured, mismatch;
    logic [1:0] mode = 2'd0;
    logic       start0 = 1'b0, abort0 = 1'b0, dut_out0;
    logic [7:0] expected0 = 8'h00;
    logic [2:0] dut_in0;
    logic       busy0, done0, pass0;
    logic [7:0] captured0, mismatch0;
    int checks = 0, errors = 0;
    typedef struct {
        logic [7:0] e;
        logic [1:0] m;
        logic [7:0] cap;
        logic [7:0] mis;
        logic       pass;
    } vec_t;
    vec_t vecs[6];
    always #5 clk = ~clk;
    function automatic logic gold(input logic [2:0] x);
        return (x[2] & (x[1] ^ x[0])) | ~(x[2] | x[1] | x[0]);
    endfunction
    // mode: 0 golden 0x86 circuit, 1 stuck at 0, 2 stuck at 1, 3 inverted circuit
    assign dut_out  = mode == 2'd0 ? gold(dut_in) : mode == 2'd1 ? 1'b0 :
                      mode == 2'd2 ? 1'b1 : ~gold(dut_in);
    assign dut_out0 = gold(dut_in0);
    tt_sweep_ctrl #(.SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .expected(expected),
        .dut_out(dut_out), .dut_in(dut_in), .busy(busy), .done(done),
        .captured(captured), .mismatch(mismatch), .pass(pass)
    );
    tt_sweep_ctrl #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .expected(expected0),
        .dut_out(dut_out0), .dut_in(dut_in0), .busy(busy0), .done(done0),
        .captured(captured0), .mismatch(mismatch0), .pass(pass0)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // Runs one S=4 sweep, optionally pulsing start at pulse_k or abort/rst at stop_k (k = edges after E0)
    task automatic do_sweep(input logic [7:0] e, input logic [1:0] m, input int pulse_k,
                            input int stop_k, input bit use_rst, output int done_at, output bit seq_ok);
        bit         stopped;
        logic [2:0] ein;
        @(negedge clk);
        expected = e;
        mode     = m;
        start    = 1'b1;
        abort    = 1'b0;
        @(posedge clk);
        #1;
        start   = 1'b0;
        done_at = -1;
        seq_ok  = 1'b1;
        for (int k = 0; k <= 42; k++) begin
            stopped = stop_k >= 0 && k > stop_k;
            ein     = (stopped || k >= 40) ? 3'd0 : 3'(k / 5);
            if (dut_in !== ein || busy !== (!stopped && k < 40) || done !== (!stopped && k == 40))
                seq_ok = 1'b0;
            if (done === 1'b1 && done_at < 0) done_at = k;
            start = k == pulse_k;
            abort = !use_rst && k == stop_k;
            rst   = use_rst && k == stop_k;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask
    initial begin
        int done_at;
        bit seq_ok;
        vecs[0] = '{8'h86, 2'd0, 8'h86, 8'h00, 1'b1};
        vecs[1] = '{8'h86, 2'd1, 8'h00, 8'h86, 1'b0};
        vecs[2] = '{8'h86, 2'd2, 8'hFF, 8'h79, 1'b0};
        vecs[3] = '{8'h79, 2'd0, 8'h86, 8'hFF, 1'b0};
        vecs[4] = '{8'h86, 2'd3, 8'h79, 8'hFF, 1'b0};
        vecs[5] = '{8'h00, 2'd1, 8'h00, 8'h00, 1'b1};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dut_in", 32'(dut_in), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_captured", 32'(captured), 32'(0));
        chk("rst_mismatch", 32'(mismatch), 32'(0));
        chk("rst_pass", 32'(pass), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            do_sweep(vecs[i].e, vecs[i].m, -1, -1, 1'b0, done_at, seq_ok);
            chk($sformatf("v%0d_done_at", i), 32'(done_at), 32'(40));
            chk($sformatf("v%0d_seq", i), 32'(seq_ok), 32'(1));
            chk($sformatf("v%0d_captured", i), 32'(captured), 32'(vecs[i].cap));
            chk($sformatf("v%0d_mismatch", i), 32'(mismatch), 32'(vecs[i].mis));
            chk($sformatf("v%0d_pass", i), 32'(pass), 32'(vecs[i].pass));
        end
        // abort in the middle of row 3, stuck-at-1 output
        do_sweep(8'h86, 2'd2, -1, 16, 1'b0, done_at, seq_ok);
        chk("abort_done_at", 32'(done_at), 32'hFFFF_FFFF);
        chk("abort_seq", 32'(seq_ok), 32'(1));
        chk("abort_captured", 32'(captured), 32'(8'hE0));
        chk("abort_mismatch", 32'(mismatch), 32'(8'h60));
        chk("abort_pass", 32'(pass), 32'(0));
        // start pulsed during RUN must not restart
        do_sweep(8'h86, 2'd0, 12, -1, 1'b0, done_at, seq_ok);
        chk("restart_done_at", 32'(done_at), 32'(40));
        chk("restart_seq", 32'(seq_ok), 32'(1));
        chk("restart_pass", 32'(pass), 32'(1));
        // start with abort in IDLE: no sweep, results untouched
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("collide_busy", 32'(busy), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("collide_busy_later", 32'(busy), 32'(0));
        chk("collide_captured", 32'(captured), 32'(8'h86));
        chk("collide_pass", 32'(pass), 32'(1));
        // reset while row 5 is driven
        do_sweep(8'h86, 2'd0, -1, 26, 1'b1, done_at, seq_ok);
        chk("rstrun_done_at", 32'(done_at), 32'hFFFF_FFFF);
        chk("rstrun_seq", 32'(seq_ok), 32'(1));
        chk("rstrun_captured", 32'(captured), 32'(0));
        chk("rstrun_mismatch", 32'(mismatch), 32'(0));
        chk("rstrun_pass", 32'(pass), 32'(0));
        do_sweep(8'h86, 2'd0, -1, -1, 1'b0, done_at, seq_ok);
        chk("after_rst_done_at", 32'(done_at), 32'(40));
        chk("after_rst_seq", 32'(seq_ok), 32'(1));
        chk("after_rst_captured", 32'(captured), 32'(8'h86));
        chk("after_rst_pass", 32'(pass), 32'(1));
        // S=0: one row per cycle, done 8 edges after start
        @(negedge clk);
        expected0 = 8'h86;
        start0    = 1'b1;
        @(posedge clk);
        #1;
        start0  = 1'b0;
        done_at = -1;
        seq_ok  = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            if (dut_in0 !== (k < 8 ? 3'(k) : 3'd0) || busy0 !== (k < 8) || done0 !== (k == 8))
                seq_ok = 1'b0;
            if (done0 === 1'b1 && done_at < 0) done_at = k;
            @(posedge clk);
            #1;
        end
        chk("s0_done_at", 32'(done_at), 32'(8));
        chk("s0_seq", 32'(seq_ok), 32'(1));
        chk("s0_captured", 32'(captured0), 32'(8'h86));
        chk("s0_mismatch", 32'(mismatch0), 32'(0));
        chk("s0_pass", 32'(pass0), 32'(1));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
